// File: rtl/mux_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux_arb_pkg
// Shared types and constants for the two-requester round-robin mux arbiter.
//   arb_state_e : arbiter FSM states (IDLE, OWN_A, OWN_B)
//   SEL_A/SEL_B : mux select encodings, also used to record the last winner
// ---------------------------------------------------------------------------
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_2to1_bus.sv
// ---------------------------------------------------------------------------
// mux_2to1_bus
// Purely combinational DATA_W-wide 2:1 multiplexer.
// Ports:
//   i_sel  in  1       : 0 selects i_a, 1 selects i_b
//   i_a    in  DATA_W  : input 0
//   i_b    in  DATA_W  : input 1
//   o_y    out DATA_W  : selected input
// ---------------------------------------------------------------------------
module mux_2to1_bus #(
  parameter int DATA_W = 8
) (
  input  logic              i_sel,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter
// Round-robin arbiter that shares one 2:1 datapath mux between two streaming
// requesters (A, B). Ownership is granted per transaction and released on a
// last beat, on reaching the beat limit, or when the owner drops its request.
// Ports:
//   clk_in, rst_n_in            : clock (rising edge), async active-low reset
//   a_req_in/a_data_in/a_last_in: requester A beat interface, a_ack_out accept
//   b_req_in/b_data_in/b_last_in: requester B beat interface, b_ack_out accept
//   y_valid_out/y_data_out      : downstream beat, y_ready_in back-pressure
//   sel_out                     : mux select (0 = A, 1 = B)
//   busy_out                    : a grant is active
// ---------------------------------------------------------------------------
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              a_req_in,
  input  logic [DATA_W-1:0] a_data_in,
  input  logic              a_last_in,
  output logic              a_ack_out,
  input  logic              b_req_in,
  input  logic [DATA_W-1:0] b_data_in,
  input  logic              b_last_in,
  output logic              b_ack_out,
  output logic              y_valid_out,
  output logic [DATA_W-1:0] y_data_out,
  input  logic              y_ready_in,
  output logic              sel_out,
  output logic              busy_out
);

  localparam int CNT_W = (MAX_BEATS < 1) ? 1 : $clog2(MAX_BEATS + 1);
  // Count value of the final beat allowed within one grant.
  localparam logic [CNT_W-1:0] BEAT_LIMIT =
    (MAX_BEATS == 0) ? '0 : CNT_W'(MAX_BEATS - 1);

  arb_state_e       r_state;
  arb_state_e       w_nextState;
  logic             r_lastWinner;
  logic             r_sel;
  logic [CNT_W-1:0] r_beatCnt;

  logic w_ownA;
  logic w_ownB;
  logic w_ownReq;
  logic w_ownLast;
  logic w_ownAck;
  logic w_atLimit;
  logic w_release;

  assign w_ownA    = (r_state == OWN_A);
  assign w_ownB    = (r_state == OWN_B);
  assign w_ownReq  = w_ownB ? b_req_in  : a_req_in;
  assign w_ownLast = w_ownB ? b_last_in : a_last_in;
  assign w_ownAck  = (w_ownA | w_ownB) & w_ownReq & y_ready_in;
  assign w_atLimit = (MAX_BEATS != 0) && (r_beatCnt == BEAT_LIMIT);

  // The owner gives up the grant on an accepted final/limit beat, or at once
  // if it abandons the transaction by dropping its request.
  assign w_release = (w_ownA | w_ownB) &
                     (~w_ownReq | (w_ownAck & (w_ownLast | w_atLimit)));

  // Next-state: ties in IDLE go to whoever did not win last; on release the
  // other requester is preferred so handover has no idle bubble.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (a_req_in && b_req_in)
          w_nextState = (r_lastWinner == SEL_A) ? OWN_B : OWN_A;
        else if (a_req_in)
          w_nextState = OWN_A;
        else if (b_req_in)
          w_nextState = OWN_B;
      end
      OWN_A: begin
        if (w_release)
          w_nextState = b_req_in ? OWN_B : (a_req_in ? OWN_A : IDLE);
      end
      OWN_B: begin
        if (w_release)
          w_nextState = a_req_in ? OWN_A : (b_req_in ? OWN_B : IDLE);
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State, fairness history, registered select and beat counter. The select
  // only changes when a grant is taken, so sel_out never sees req inputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state      <= IDLE;
      r_lastWinner <= SEL_B;
      r_sel        <= SEL_A;
      r_beatCnt    <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_release)
        r_lastWinner <= w_ownB ? SEL_B : SEL_A;
      if (w_nextState == OWN_A)
        r_sel <= SEL_A;
      else if (w_nextState == OWN_B)
        r_sel <= SEL_B;
      if (w_release || (MAX_BEATS == 0))
        r_beatCnt <= '0;
      else if (w_ownAck)
        r_beatCnt <= r_beatCnt + CNT_W'(1);
    end
  end

  mux_2to1_bus #(
    .DATA_W (DATA_W)
  ) u_dataMux (
    .i_sel (r_sel),
    .i_a   (a_data_in),
    .i_b   (b_data_in),
    .o_y   (y_data_out)
  );

  assign a_ack_out   = w_ownA & a_req_in & y_ready_in;
  assign b_ack_out   = w_ownB & b_req_in & y_ready_in;
  assign y_valid_out = (w_ownA & a_req_in) | (w_ownB & b_req_in);
  assign sel_out     = r_sel;
  assign busy_out    = w_ownA | w_ownB;

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 2:1 datapath mux between two streaming requesters (A, B).
- Grants ownership per transaction (ends on last beat or beat limit) and drives the mux select.
- Presents the selected stream downstream with a valid/ready handshake.
- Sits in front of any single-consumer resource fed by two sources.

Parameters:
- DATA_W, 8, width of each data bus.
- MAX_BEATS, 16, max accepted beats per grant before forced release; 0 = unlimited.
- CNT_W, derived localparam = clog2(MAX_BEATS+1) (min 1), width of the beat counter.

Ports:
- clk_in  in  1  single clock, rising edge.
- rst_n_in  in  1  asynchronous, active-low reset.
- a_req_in  in  1  A has a valid beat / holds request.
- a_data_in  in  DATA_W  A beat data.
- a_last_in  in  1  A beat is the final beat of its transaction.
- a_ack_out  out  1  A beat accepted this cycle.
- b_req_in, b_data_in, b_last_in, b_ack_out: same as A, for requester B.
- y_valid_out  out  1  downstream beat valid.
- y_data_out  out  DATA_W  downstream data (mux output).
- y_ready_in  in  1  downstream can accept.
- sel_out  out  1  mux select; 0 = A, 1 = B.
- busy_out  out  1  a grant is active.

Behaviour:
- State machine: IDLE, OWN_A, OWN_B. Registered state; regs last_winner, sel_q, beat_cnt[CNT_W].
- Async reset: state=IDLE, last_winner=B (A wins first tie), sel_q=0, beat_cnt=0. All outputs then read 0 except y_data_out (= a_data_in, since sel=0).
- IDLE:
  - Only one request high: grant that requester at the next edge.
  - Both high: grant the requester that is not last_winner.
  - Grant latency is 1 cycle. No acks in IDLE.
- OWN_x:
  - sel_out = (state==OWN_B); sel_q tracks it.
  - y_valid_out = x_req_in; y_data_out = x_data_in.
  - x_ack_out = x_req_in & y_ready_in. The other ack is 0.
  - Beat accepted when x_ack_out=1. beat_cnt increments on each accepted beat.
- Release from OWN_x at the clock edge when any of these holds:
  - an accepted beat has x_last_in=1;
  - MAX_BEATS!=0 and an accepted beat has beat_cnt==MAX_BEATS-1;
  - x_req_in==0 (abandoned transaction).
- On release:
  - last_winner=x and beat_cnt=0.
  - Next state: OWN_other if the other req is high at that edge (zero-bubble handover). Otherwise OWN_x if x_req_in is still high. Otherwise IDLE.
- IDLE: sel_out holds sel_q; y_valid_out=0; busy_out=0. busy_out=1 in OWN_A/OWN_B.
- Downstream stall (y_ready_in=0): grant held indefinitely, beat_cnt frozen, data passes through unregistered.
- Combinational paths: ack depends combinationally on y_ready_in. y_data_out depends combinationally on data inputs and registered sel. No path exists from req inputs to sel_out.
- Reset asserted mid-transaction: immediate return to reset values. Acks and valid drop asynchronously. The in-flight transaction is abandoned; requesters restart it.
- Width rules:
  - beat_cnt never wraps; it is cleared on release.
  - With MAX_BEATS=0, beat_cnt is unused and held at 0.

Decomposition:
- Package mux_arb_pkg: state enum (IDLE=2'd0, OWN_A=2'd1, OWN_B=2'd2), constants SEL_A=1'b0, SEL_B=1'b1.
- Sub-module mux_2to1_bus: DATA_W-wide combinational 2:1 mux (sel=1 selects b). Instantiated once for the y_data_out path.
- The FSM, counter and ack logic stay in mux_rr_arbiter.

Test Plan:
- Reset then a_req=1, b_req=0, data 0x11/0x22 with last on beat 2, ready=1 -> cycle 1 OWN_A, y_data 0x11 then 0x22, a_ack high 2 cycles, then IDLE, sel_out stays 0.
- a_req and b_req raised the same cycle after reset, each a 1-beat transaction -> A granted first; B granted at A's release edge with no IDLE cycle; sel_out 0 then 1.
- B streams continuously with no last, MAX_BEATS=4, A requesting -> B gets exactly 4 acks, then A owns; after A's last beat, B is re-granted.
- OWN_A with y_ready=0 for 5 cycles, then 1 -> no acks, beat_cnt holds, y_valid=1 with a_data steady; transfer resumes on ready.
- In OWN_A, a_req drops with no last, b_req=0 -> IDLE next edge, last_winner=A; next simultaneous request grants B.
- rst_n_in pulsed low mid-OWN_B beat 3 -> b_ack, y_valid, busy and sel drop immediately; after release, A wins the first tie.
